// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB4 memory slave with programmable wait states, byte strobes
// and address/alignment error responses. Its depth and data width are
// parameters.
// Optional feature macro: APB_MEM_PROT_EN. When it is defined, a non-secure
// access (PPROT[1]=1) to a word index at or above NS_LIMIT is rejected.
// Ports:
//   PCLK, PRESETn       clock, asynchronous active-low reset
//   PADDR               byte address (word index = upper bits)
//   PSEL/PENABLE/PWRITE APB control
//   PWDATA/PSTRB        write data and byte enables
//   PPROT               protection attributes (bit 1 = non-secure)
//   PRDATA              read data, loaded on the read setup edge
//   PREADY/PSLVERROR    completion and error, decoded from the access state
module apb_mem_slave #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned NS_LIMIT    = DEPTH / 2
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERROR
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int unsigned MEM_AW = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [MEM_AW-1:0]     idx_q;
  logic                  write_q;
  logic [STRB_W-1:0]     strb_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx_c;
  logic [OFF_W-1:0]  off_c;
  logic [MEM_AW-1:0] mem_idx_c;
  logic              range_err_c;
  logic              prot_err_c;
  logic              err_c;
  logic              setup_c;
  logic              commit_c;

  // Address decode for the error check at the setup edge
  assign idx_c       = PADDR[ADDR_WIDTH-1:OFF_W];
  assign off_c       = PADDR[OFF_W-1:0];
  assign mem_idx_c   = idx_c[MEM_AW-1:0];
  assign range_err_c = (64'(idx_c) >= 64'(DEPTH));

`ifdef APB_MEM_PROT_EN
  logic unused_prot;
  assign prot_err_c  = PPROT[1] && (64'(idx_c) >= 64'(NS_LIMIT));
  assign unused_prot = ^{PPROT[2], PPROT[0]};
`else
  logic unused_prot;
  assign prot_err_c  = 1'b0;
  assign unused_prot = ^{PPROT, 1'(NS_LIMIT)};
`endif

  assign err_c = (off_c != '0) || range_err_c || prot_err_c;

  // Next state plus completion/error decode (PREADY only in ACCESS with counter at 0)
  always_comb begin
    state_d   = state_q;
    PREADY    = 1'b0;
    PSLVERROR = 1'b0;
    setup_c   = 1'b0;
    commit_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          setup_c = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        PREADY    = (cnt_q == '0);
        PSLVERROR = (cnt_q == '0) && err_q;
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (PENABLE && (cnt_q == '0)) begin
          commit_c = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Transfer capture, wait counter and read data
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      PRDATA  <= '0;
    end else if (setup_c) begin
      cnt_q   <= CNT_W'(WAIT_CYCLES);
      idx_q   <= mem_idx_c;
      write_q <= PWRITE;
      strb_q  <= PSTRB;
      wdata_q <= PWDATA;
      err_q   <= err_c;
      if (!PWRITE) PRDATA <= err_c ? '0 : mem[mem_idx_c];
    end else if ((state_q == ST_ACCESS) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Storage array (not reset); byte lanes commit on an error-free write completion
  always_ff @(posedge PCLK) begin
    if (PRESETn && commit_c && write_q && !err_q) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: drives two slaves (WAIT_CYCLES=0 and 3) from one shared APB bus.
// Expected responses are queued at setup and checked when PREADY is seen.
module tb_apb_mem_slave;

  localparam int unsigned DEPTH    = 256;
  localparam int unsigned NS_LIMIT = DEPTH / 2;
`ifdef APB_MEM_PROT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] paddr, pwdata;
  logic [1:0]  psel;
  logic        penable, pwrite;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, perr0, perr3;

  always #5 clk = ~clk;

  apb_mem_slave #(.WAIT_CYCLES(0)) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERROR(perr0)
  );

  apb_mem_slave #(.WAIT_CYCLES(3)) u_dut3 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERROR(perr3)
  );

  typedef struct {
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [int];
  int          total = 0;
  int          bad   = 0;
  time         t_a, t_b, t_x;

  function automatic bit exp_err(input logic [31:0] a, input logic [2:0] p);
    bit e;
    e = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    if (PROT_ON && p[1] && ((a >> 2) >= 32'(NS_LIMIT))) e = 1'b1;
    return e;
  endfunction

  function automatic logic rdy(input int d);
    return (d == 0) ? pready0 : pready3;
  endfunction

  function automatic logic err_of(input int d);
    return (d == 0) ? perr0 : perr3;
  endfunction

  function automatic logic [31:0] data_of(input int d);
    return (d == 0) ? prdata0 : prdata3;
  endfunction

  // One full APB transfer on slave d; returns time just after the completion edge
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [2:0] prot, input bit scramble, output time t_done);
    exp_t        e, got;
    int          lows, wexp, key;
    logic [31:0] w;
    wexp   = (d == 0) ? 0 : 3;
    key    = d * 1024 + int'(addr >> 2);
    e.err  = exp_err(addr, prot);
    e.data = 32'h0;
    if (!wr && !e.err) e.data = model.exists(key) ? model[key] : 32'hx;
    exp_q.push_back(e);
    @(negedge clk);
    paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; pprot = prot;
    penable = 1'b0; psel = 2'b00; psel[d] = 1'b1;
    @(negedge clk);
    penable = 1'b1;
    if (scramble) begin
      paddr = addr ^ 32'h44; pwdata = ~wdata; pstrb = ~strb; pwrite = ~wr; pprot = ~prot;
    end
    lows = 0;
    while (rdy(d) !== 1'b1 && lows < 40) begin
      lows++;
      @(negedge clk);
    end
    got = exp_q.pop_front();
    total++;
    if (lows !== wexp) begin
      bad++; $display("FAIL wait_states addr=%h: got %0d want %0d", addr, lows, wexp);
    end
    total++;
    if (err_of(d) !== got.err) begin
      bad++; $display("FAIL pslverror addr=%h: got %b want %b", addr, err_of(d), got.err);
    end
    if (!wr) begin
      total++;
      if (data_of(d) !== got.data) begin
        bad++; $display("FAIL prdata addr=%h: got %h want %h", addr, data_of(d), got.data);
      end
    end
    if (wr && !got.err) begin
      w = model.exists(key) ? model[key] : 32'hx;
      for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = wdata[8*i +: 8];
      model[key] = w;
    end
    @(posedge clk);
    #1;
    psel = 2'b00; penable = 1'b0;
    t_done = $time;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(negedge clk);
    total++; if (pready0 !== 1'b0) begin bad++; $display("FAIL reset_pready0: got %b want 0", pready0); end
    total++; if (perr0 !== 1'b0) begin bad++; $display("FAIL reset_perr0: got %b want 0", perr0); end
    total++; if (prdata0 !== 32'h0) begin bad++; $display("FAIL reset_prdata0: got %h want 0", prdata0); end
    total++; if (pready3 !== 1'b0) begin bad++; $display("FAIL reset_pready3: got %b want 0", pready3); end
    total++; if (prdata3 !== 32'h0) begin bad++; $display("FAIL reset_prdata3: got %h want 0", prdata3); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0, t_x);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1'b0, t_a);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000, 1'b0, t_b);
    total++;
    if ((t_b - t_a) !== 20) begin bad++; $display("FAIL b2b_wait0: got %0t want 20", t_b - t_a); end
  endtask

  task automatic test_wait_b2b;
    xfer(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0, t_x);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1'b0, t_a);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1'b0, t_b);
    total++;
    if ((t_b - t_a) !== 50) begin bad++; $display("FAIL b2b_wait3: got %0t want 50", t_b - t_a); end
  endtask

  task automatic test_strobe;
    xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 3'b000, 1'b0, t_x);
    xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 3'b000, 1'b0, t_x);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, 1'b0, t_x);
    total++;
    if (prdata0 !== 32'h11BB33DD) begin bad++; $display("FAIL strobe_merge: got %h want 11bb33dd", prdata0); end
    xfer(0, 1'b1, 32'h20, 32'h99999999, 4'h0, 3'b000, 1'b0, t_x);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, 1'b0, t_x);
  endtask

  task automatic test_errors;
    xfer(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 3'b000, 1'b0, t_x);
    xfer(0, 1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, 3'b000, 1'b0, t_x);
    xfer(0, 1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, 3'b000, 1'b0, t_x);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 1'b0, t_x);
    xfer(0, 1'b0, 32'h2, 32'h0, 4'h0, 3'b000, 1'b0, t_x);
    xfer(0, 1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, 3'b000, 1'b0, t_x);
    xfer(0, 1'b0, 32'h3, 32'h0, 4'h0, 3'b000, 1'b0, t_x);
  endtask

  task automatic test_prot;
    logic [31:0] want;
    xfer(0, 1'b1, 32'd800, 32'h0BADF00D, 4'hF, 3'b000, 1'b0, t_x);
    xfer(0, 1'b1, 32'd800, 32'h12345678, 4'hF, 3'b010, 1'b0, t_x);
    xfer(0, 1'b0, 32'd800, 32'h0, 4'h0, 3'b000, 1'b0, t_x);
    want = PROT_ON ? 32'h0BADF00D : 32'h12345678;
    total++;
    if (prdata0 !== want) begin bad++; $display("FAIL prot_write: got %h want %h", prdata0, want); end
    xfer(0, 1'b0, 32'd800, 32'h0, 4'h0, 3'b010, 1'b0, t_x);
    xfer(0, 1'b1, 32'h40, 32'h5A5A0001, 4'hF, 3'b010, 1'b0, t_x);
    xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b010, 1'b0, t_x);
    xfer(0, 1'b1, 32'd800, 32'h87654321, 4'hF, 3'b000, 1'b0, t_x);
    xfer(0, 1'b0, 32'd800, 32'h0, 4'h0, 3'b000, 1'b0, t_x);
  endtask

  task automatic test_idle_penable;
    @(negedge clk);
    psel = 2'b01; penable = 1'b1; pwrite = 1'b0; paddr = 32'h10;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (pready0 !== 1'b0) begin bad++; $display("FAIL idle_penable_pready: got %b want 0", pready0); end
    end
    total++;
    if (prdata0 !== 32'h87654321) begin bad++; $display("FAIL idle_penable_prdata: got %h want 87654321", prdata0); end
    psel = 2'b00; penable = 1'b0;
  endtask

  task automatic test_abort;
    @(negedge clk);
    psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0; pstrb = 4'hF;
    @(negedge clk);
    psel = 2'b00;
    @(negedge clk);
    total++;
    if (pready3 !== 1'b0) begin bad++; $display("FAIL abort_pready: got %b want 0", pready3); end
    total++;
    if (prdata3 !== 32'hDEADBEEF) begin bad++; $display("FAIL abort_prdata_hold: got %h want deadbeef", prdata3); end
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1'b0, t_x);
    xfer(1, 1'b1, 32'h14, 32'h01020304, 4'hF, 3'b000, 1'b0, t_x);
    xfer(1, 1'b0, 32'h14, 32'h0, 4'h0, 3'b000, 1'b0, t_x);
  endtask

  task automatic test_scramble;
    xfer(0, 1'b1, 32'h30, 32'h55AA55AA, 4'hF, 3'b000, 1'b1, t_x);
    xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, 3'b000, 1'b1, t_x);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    psel = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'h0; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    total++;
    if (pready0 !== 1'b1) begin bad++; $display("FAIL mid_pre_pready: got %b want 1", pready0); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (pready0 !== 1'b0) begin bad++; $display("FAIL mid_reset_pready: got %b want 0", pready0); end
    total++; if (perr0 !== 1'b0) begin bad++; $display("FAIL mid_reset_perr: got %b want 0", perr0); end
    total++; if (prdata0 !== 32'h0) begin bad++; $display("FAIL mid_reset_prdata: got %h want 0", prdata0); end
    psel = 2'b00; penable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, 3'b000, 1'b0, t_x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_wait_b2b();
    test_strobe();
    test_errors();
    test_prot();
    test_idle_penable();
    test_abort();
    test_scramble();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
